// File: rtl/led_bank_ctrl.sv
// Memory-mapped LED output bank: data/blink/control registers, blink timer,
// PWM brightness and a registered LED drive stage on the MemOrIO bus.
module led_bank_ctrl #(
  parameter int unsigned NUM_LEDS  = 24,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned PWM_BITS  = 4
) (
  input  logic                led_clk,
  input  logic                ledrst,
  input  logic                ledcs,
  input  logic                ledwrite,
  input  logic [3:0]          ledaddr,
  input  logic [15:0]         ledwdata,
  output logic [15:0]         ledrdata,
  output logic [NUM_LEDS-1:0] ledout
);

  localparam int unsigned BCNT_W = $clog2(BLINK_DIV);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLINK_DIV - 1);

  localparam logic [3:0] ADDR_DATA_LO  = 4'h0;
  localparam logic [3:0] ADDR_DATA_HI  = 4'h2;
  localparam logic [3:0] ADDR_BLINK_LO = 4'h4;
  localparam logic [3:0] ADDR_BLINK_HI = 4'h6;
  localparam logic [3:0] ADDR_CTRL     = 4'h8;

  // Architectural registers
  logic [NUM_LEDS-1:0] r_data;
  logic [NUM_LEDS-1:0] r_blink;
  logic                r_en;
  logic [PWM_BITS-1:0] r_duty;
  logic [BCNT_W-1:0]   r_blink_cnt;
  logic                r_blink_phase;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  // Next-state and datapath wires
  logic                w_wr;
  logic                w_rd;
  logic                w_blink_wr;
  logic [NUM_LEDS-1:0] w_data_nxt;
  logic [NUM_LEDS-1:0] w_blink_nxt;
  logic                w_en_nxt;
  logic [PWM_BITS-1:0] w_duty_nxt;
  logic [BCNT_W-1:0]   w_blink_cnt_nxt;
  logic                w_blink_phase_nxt;
  logic [PWM_BITS-1:0] w_pwm_cnt_nxt;
  logic [31:0]         w_data32;
  logic [31:0]         w_blink32;
  logic [15:0]         w_ctrl16;
  logic [15:0]         w_rdata;
  logic                w_pwm_on;
  logic [NUM_LEDS-1:0] w_lit;
  logic [NUM_LEDS-1:0] w_led_nxt;

  assign w_wr       = ledcs & ledwrite;
  assign w_rd       = ledcs & ~ledwrite;
  assign w_blink_wr = w_wr & ((ledaddr == ADDR_BLINK_LO) | (ledaddr == ADDR_BLINK_HI));

  // Zero-padded 32-bit views so unimplemented LED bits read back as 0
  assign w_data32  = 32'(r_data);
  assign w_blink32 = 32'(r_blink);
  assign w_ctrl16  = 16'(r_en) | (16'(r_duty) << 4);

  // Register write decode: only the addressed 16-bit half changes
  always_comb begin
    w_data_nxt  = r_data;
    w_blink_nxt = r_blink;
    w_en_nxt    = r_en;
    w_duty_nxt  = r_duty;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (w_wr && (ledaddr == ((i < 16) ? ADDR_DATA_LO : ADDR_DATA_HI))) begin
        w_data_nxt[i] = ledwdata[i % 16];
      end
      if (w_wr && (ledaddr == ((i < 16) ? ADDR_BLINK_LO : ADDR_BLINK_HI))) begin
        w_blink_nxt[i] = ledwdata[i % 16];
      end
    end
    if (w_wr && (ledaddr == ADDR_CTRL)) begin
      w_en_nxt   = ledwdata[0];
      w_duty_nxt = ledwdata[PWM_BITS+3:4];
    end
  end

  // Readback mux; unmapped offsets read 0
  always_comb begin
    w_rdata = 16'h0000;
    case (ledaddr)
      ADDR_DATA_LO:  w_rdata = w_data32[15:0];
      ADDR_DATA_HI:  w_rdata = w_data32[31:16];
      ADDR_BLINK_LO: w_rdata = w_blink32[15:0];
      ADDR_BLINK_HI: w_rdata = w_blink32[31:16];
      ADDR_CTRL:     w_rdata = w_ctrl16;
      default:       w_rdata = 16'h0000;
    endcase
  end

  // Blink timer; a blink-mask write resyncs it so blinking LEDs restart lit
  always_comb begin
    w_blink_cnt_nxt   = r_blink_cnt + BCNT_W'(1);
    w_blink_phase_nxt = r_blink_phase;
    if (w_blink_wr) begin
      w_blink_cnt_nxt   = '0;
      w_blink_phase_nxt = 1'b1;
    end else if (r_blink_cnt == BCNT_MAX) begin
      w_blink_cnt_nxt   = '0;
      w_blink_phase_nxt = ~r_blink_phase;
    end
  end

  // PWM gate and LED pattern; full-scale duty is always on
  always_comb begin
    w_pwm_cnt_nxt = r_pwm_cnt + PWM_BITS'(1);
    w_pwm_on      = (r_duty == {PWM_BITS{1'b1}}) | (r_pwm_cnt < r_duty);
    w_lit         = r_data & (~r_blink | {NUM_LEDS{r_blink_phase}});
    w_led_nxt     = (r_en & w_pwm_on) ? w_lit : '0;
  end

  // State, readback and output registers; reset wins over any access
  always_ff @(posedge led_clk) begin
    if (ledrst) begin
      r_data        <= '0;
      r_blink       <= '0;
      r_en          <= 1'b1;
      r_duty        <= {PWM_BITS{1'b1}};
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_pwm_cnt     <= '0;
      ledrdata      <= 16'h0000;
      ledout        <= '0;
    end else begin
      r_data        <= w_data_nxt;
      r_blink       <= w_blink_nxt;
      r_en          <= w_en_nxt;
      r_duty        <= w_duty_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      r_pwm_cnt     <= w_pwm_cnt_nxt;
      ledout        <= w_led_nxt;
      if (w_rd) begin
        ledrdata <= w_rdata;
      end
    end
  end

endmodule
